// File: rtl/unidad_control.sv
// Hardwired two-phase (FETCH/EXEC) control unit: fetches 8-bit instructions from a
// combinational program ROM and decodes them into the datapath's 16-bit control word.
module unidad_control #(
  parameter int PC_W = 4,
  parameter int IW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [IW-1:0]   instr,
  input  logic [3:0]      flags,
  output logic [PC_W-1:0] prog_addr,
  output logic [15:0]     control,
  output logic            halted,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_ADR  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [IW-1:0]   ir_q;

  logic [3:0] opcode;
  logic [3:0] operand;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       jump_d;
  logic [PC_W-1:0] jump_target_d;

  // Control word fields, assembled in decode.
  logic [3:0] alu_op_d;
  logic [1:0] src_a_d;
  logic [1:0] src_b_d;
  logic [1:0] dst_d;
  logic       reg_we_d;
  logic       sel_in_d;
  logic       flags_we_d;
  logic       out_we_d;
  logic       adr_we_d;

  // N and V are produced by the datapath but no branch here consumes them.
  logic unused_flags;
  assign unused_flags = ^flags[1:0];

  assign opcode        = ir_q[IW-1 -: 4];
  assign operand       = ir_q[3:0];
  assign rd            = operand[3:2];
  assign rs            = operand[1:0];
  assign jump_target_d = PC_W'(operand);

  always_comb begin
    jump_d = 1'b0;
    case (opcode)
      OP_JMP:  jump_d = 1'b1;
      OP_JZ:   jump_d = flags[3];
      OP_JC:   jump_d = flags[2];
      default: jump_d = 1'b0;
    endcase
  end

  always_comb begin
    alu_op_d   = 4'h0;
    src_a_d    = 2'b00;
    src_b_d    = 2'b00;
    dst_d      = 2'b00;
    reg_we_d   = 1'b0;
    sel_in_d   = 1'b0;
    flags_we_d = 1'b0;
    out_we_d   = 1'b0;
    adr_we_d   = 1'b0;
    if (state_q == S_EXEC) begin
      case (opcode)
        OP_LOAD: begin
          dst_d    = rd;
          reg_we_d = 1'b1;
          sel_in_d = 1'b1;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          alu_op_d   = opcode;
          src_a_d    = rd;
          src_b_d    = rs;
          dst_d      = rd;
          reg_we_d   = 1'b1;
          flags_we_d = 1'b1;
        end
        OP_NOT: begin
          alu_op_d   = OP_NOT;
          src_a_d    = rd;
          dst_d      = rd;
          reg_we_d   = 1'b1;
          flags_we_d = 1'b1;
        end
        OP_OUT: begin
          src_a_d  = rs;
          out_we_d = 1'b1;
        end
        OP_ADR: begin
          src_a_d  = rs;
          adr_we_d = 1'b1;
        end
        // NOP, jumps, 0xD/0xE and HALT drive an all-zero word.
        default: ;
      endcase
    end
  end

  // Combinational from state so an async reset silences the datapath instantly.
  assign control = {alu_op_d, src_a_d, src_b_d, dst_d, reg_we_d, sel_in_d,
                    flags_we_d, out_we_d, adr_we_d, 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          ir_q    <= instr;
          pc_q    <= pc_q + PC_W'(1);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (jump_d) pc_q <= jump_target_d;
          state_q <= (opcode == OP_HALT) ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign prog_addr = pc_q;
  assign halted    = (state_q == S_HALT);
  assign state_o   = state_q;

endmodule

// File: tb/tb_unidad_control.sv
// Directed bench for unidad_control: ROM model, reset, decode, jumps, pc wrap, async abort.
module tb_unidad_control;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  instr;
  logic [3:0]  flags = 4'b0000;
  logic [3:0]  prog_addr;
  logic [15:0] control;
  logic        halted;
  logic [1:0]  state_o;

  logic [7:0] rom [16];

  int n_checks = 0;
  int n_fail   = 0;

  assign instr = rom[prog_addr];

  unidad_control #(.PC_W(4), .IW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .instr     (instr),
    .flags     (flags),
    .prog_addr (prog_addr),
    .control   (control),
    .halted    (halted),
    .state_o   (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse start at a negedge; returns at the negedge where the DUT sits in FETCH.
  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    clear_rom();
    do_reset();

    // Reset behaviour: abort a running program, then idle with start low.
    start_run();
    step(); step(); step();
    #2 reset = 1'b1;
    #1 check("rst_ctrl_immediate", 32'(control), 32'h0000);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_state", 32'(state_o), 32'(ST_IDLE));
      check("idle_ctrl", 32'(control), 32'h0000);
      check("idle_pc", 32'(prog_addr), 32'h0);
      check("idle_halted", 32'(halted), 32'h0);
    end

    // LOAD r1 / OUT r1 / HALT, then restart from HALT.
    clear_rom();
    rom[0] = 8'h14; rom[1] = 8'h81; rom[2] = 8'hF0;
    start_run();
    check("fetch_ctrl", 32'(control), 32'h0000);
    step();
    check("load_ctrl", 32'(control), 32'h0070);
    check("load_pc", 32'(prog_addr), 32'h1);
    step();
    check("fetch2_state", 32'(state_o), 32'(ST_FETCH));
    step();
    check("out_ctrl", 32'(control), 32'h0404);
    step(); step();
    check("halt_exec_ctrl", 32'(control), 32'h0000);
    step();
    check("halted", 32'(halted), 32'h1);
    check("halt_ctrl", 32'(control), 32'h0000);
    step();
    check("halt_stays", 32'(state_o), 32'(ST_HALT));
    start_run();
    check("restart_pc", 32'(prog_addr), 32'h0);
    check("restart_state", 32'(state_o), 32'(ST_FETCH));
    check("restart_halted", 32'(halted), 32'h0);

    // ALU decode: ADD r2,r3 then NOT r3.
    do_reset();
    clear_rom();
    rom[0] = 8'h2B; rom[1] = 8'h7C; rom[2] = 8'hF0;
    start_run();
    step();
    check("add_ctrl", 32'(control), 32'h2BA8);
    step(); step();
    check("not_ctrl", 32'(control), 32'h7CE8);

    // Conditional jumps at address 3: {instr, flags, expected next pc}.
    begin
      logic [7:0]  jv_ins [6];
      logic [3:0]  jv_flg [6];
      logic [3:0]  jv_pc  [6];
      jv_ins = '{8'hB8, 8'hB8, 8'hB8, 8'hC9, 8'hC9, 8'hA7};
      jv_flg = '{4'b1000, 4'b0000, 4'b0111, 4'b0100, 4'b1000, 4'b0000};
      jv_pc  = '{4'h8, 4'h4, 4'h4, 4'h9, 4'h4, 4'h7};
      for (int v = 0; v < 6; v++) begin
        do_reset();
        clear_rom();
        rom[3] = jv_ins[v];
        flags = jv_flg[v];
        start_run();
        for (int k = 0; k < 3; k++) begin step(); step(); end
        check("br_fetch_pc", 32'(prog_addr), 32'h3);
        step();
        check("br_exec_ctrl", 32'(control), 32'h0000);
        step();
        check($sformatf("br_next_pc_%0d", v), 32'(prog_addr), 32'(jv_pc[v]));
      end
      flags = 4'b0000;
    end

    // PC wrap over an all-NOP ROM.
    do_reset();
    clear_rom();
    start_run();
    for (int i = 0; i <= 16; i++) begin
      check($sformatf("wrap_pc_%0d", i), 32'(prog_addr), 32'(i % 16));
      step(); step();
    end

    // JMP 5 placed at the last address.
    do_reset();
    rom[15] = 8'hA5;
    start_run();
    for (int i = 0; i < 15; i++) begin step(); step(); end
    check("jmp_fetch_pc", 32'(prog_addr), 32'hF);
    step(); step();
    check("jmp_target_pc", 32'(prog_addr), 32'h5);

    // Self-loop JMP stays put.
    do_reset();
    clear_rom();
    rom[2] = 8'hA2;
    start_run();
    for (int i = 0; i < 5; i++) begin step(); step(); end
    check("selfloop_pc", 32'(prog_addr), 32'h2);

    // Async reset in the middle of an EXEC of ADD.
    do_reset();
    clear_rom();
    rom[0] = 8'h2B; rom[1] = 8'h2B;
    start_run();
    step(); step(); step();
    check("abort_pre_ctrl", 32'(control), 32'h2BA8);
    #2 reset = 1'b1;
    #1 check("abort_ctrl", 32'(control), 32'h0000);
    check("abort_pc", 32'(prog_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    start_run();
    check("abort_restart_pc", 32'(prog_addr), 32'h0);
    step();
    check("abort_restart_ctrl", 32'(control), 32'h2BA8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
